// File: rtl/clk_timer_port.sv
// clk_timer_port: MMIO register block for the free-running cycle/ms counters.
// Provides tear-free 64-bit reads via LO-read snapshots of the HI word, the
// fixed clock frequency, and a one-shot/periodic ms alarm driving a level IRQ.
module clk_timer_port (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] i_clk_count,
  input  logic [31:0] i_clk_freq,
  input  logic [63:0] i_ms_count,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [3:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ack,
  output logic [31:0] o_rdata,
  output logic        o_irq
);

  localparam logic [3:0] A_CLK_LO   = 4'd0;
  localparam logic [3:0] A_CLK_HI   = 4'd1;
  localparam logic [3:0] A_FREQ     = 4'd2;
  localparam logic [3:0] A_MS_LO    = 4'd3;
  localparam logic [3:0] A_MS_HI    = 4'd4;
  localparam logic [3:0] A_ALARM_LO = 4'd5;
  localparam logic [3:0] A_ALARM_HI = 4'd6;
  localparam logic [3:0] A_CTRL     = 4'd7;
  localparam logic [3:0] A_PERIOD   = 4'd8;

  logic [31:0] clk_shadow, ms_shadow, period;
  logic [63:0] alarm, alarm_nxt;
  logic        en, periodic, pending;
  logic        en_nxt, periodic_nxt, pending_nxt;
  logic [31:0] period_nxt;
  logic        rd, wr, fire, reload;
  logic [31:0] rd_mux;

  assign rd     = i_req & ~i_we;
  assign wr     = i_req & i_we;
  // Unsigned 64-bit compare on the live ms count, every cycle.
  assign fire   = en & (i_ms_count >= alarm);
  // A zero PERIOD would re-fire forever at the same alarm, so it degrades to one-shot.
  assign reload = periodic & (period != 32'd0);
  assign o_irq  = pending;

  // Read data mux; reflects register state before the accepting edge.
  always_comb begin
    rd_mux = 32'd0;
    case (i_addr)
      A_CLK_LO:   rd_mux = i_clk_count[31:0];
      A_CLK_HI:   rd_mux = clk_shadow;
      A_FREQ:     rd_mux = i_clk_freq;
      A_MS_LO:    rd_mux = i_ms_count[31:0];
      A_MS_HI:    rd_mux = ms_shadow;
      A_ALARM_LO: rd_mux = alarm[31:0];
      A_ALARM_HI: rd_mux = alarm[63:32];
      A_CTRL:     rd_mux = {29'd0, pending, periodic, en};
      A_PERIOD:   rd_mux = period;
      default:    rd_mux = 32'd0;
    endcase
  end

  // Next-state for alarm/ctrl: fire effects first, then bus writes override.
  always_comb begin
    alarm_nxt    = alarm;
    en_nxt       = en;
    periodic_nxt = periodic;
    pending_nxt  = pending;
    period_nxt   = period;

    if (fire) begin
      if (reload) alarm_nxt = alarm + {32'd0, period};
      else        en_nxt    = 1'b0;
    end

    if (wr) begin
      case (i_addr)
        A_ALARM_LO: begin
          alarm_nxt[31:0] = i_wdata;
          en_nxt          = 1'b0;
        end
        A_ALARM_HI: begin
          alarm_nxt[63:32] = i_wdata;
          en_nxt           = 1'b0;
        end
        A_CTRL: begin
          en_nxt       = i_wdata[0];
          periodic_nxt = i_wdata[1];
          if (i_wdata[2]) pending_nxt = 1'b0;
        end
        A_PERIOD: period_nxt = i_wdata;
        default: ;
      endcase
    end

    // A fire on the same edge as a W1C leaves pending set.
    if (fire) pending_nxt = 1'b1;
  end

  // Registered bus response: one-cycle ack, read data only for reads.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ack   <= 1'b0;
      o_rdata <= 32'd0;
    end else begin
      o_ack   <= i_req;
      o_rdata <= rd ? rd_mux : 32'd0;
    end
  end

  // HI-word snapshots taken on the same edge as the LO read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      clk_shadow <= 32'd0;
      ms_shadow  <= 32'd0;
    end else if (rd) begin
      if (i_addr == A_CLK_LO) clk_shadow <= i_clk_count[63:32];
      if (i_addr == A_MS_LO)  ms_shadow  <= i_ms_count[63:32];
    end
  end

  // Alarm, period and control state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      alarm    <= 64'd0;
      period   <= 32'd0;
      en       <= 1'b0;
      periodic <= 1'b0;
      pending  <= 1'b0;
    end else begin
      alarm    <= alarm_nxt;
      period   <= period_nxt;
      en       <= en_nxt;
      periodic <= periodic_nxt;
      pending  <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_clk_timer_port.sv
// Directed bench for clk_timer_port with a read-data scoreboard queue.
module tb_clk_timer_port;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [63:0] i_clk_count = 64'd0;
  logic [31:0] i_clk_freq  = 32'd50_000_000;
  logic [63:0] i_ms_count  = 64'd0;
  logic        i_req = 1'b0;
  logic        i_we  = 1'b0;
  logic [3:0]  i_addr = 4'd0;
  logic [31:0] i_wdata = 32'd0;
  logic        o_ack;
  logic [31:0] o_rdata;
  logic        o_irq;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  clk_timer_port dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clk_count(i_clk_count), .i_clk_freq(i_clk_freq),
    .i_ms_count(i_ms_count), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_ack(o_ack), .o_rdata(o_rdata), .o_irq(o_irq)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus transaction; expected read data (0 for writes) goes through the queue.
  task automatic bus(input string tag, input logic we, input logic [3:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp);
    @(negedge i_clk);
    i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata;
    exp_q.push_back(we ? 32'd0 : exp);
    @(posedge i_clk);
    #1;
    i_req = 1'b0; i_we = 1'b0;
    chk({tag, "_ack"}, {63'd0, o_ack}, 64'd1);
    chk(tag, {32'd0, o_rdata}, {32'd0, exp_q.pop_front()});
  endtask

  task automatic rd(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    bus(tag, 1'b0, addr, 32'd0, exp);
  endtask

  task automatic wr(input string tag, input logic [3:0] addr, input logic [31:0] data);
    bus(tag, 1'b1, addr, data, 32'd0);
  endtask

  task automatic step_ms(input logic [63:0] ms);
    @(negedge i_clk);
    i_ms_count = ms;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    // Reset state
    i_rst = 1'b1;
    #1;
    chk("rst_ack", {63'd0, o_ack}, 64'd0);
    chk("rst_rdata", {32'd0, o_rdata}, 64'd0);
    chk("rst_irq", {63'd0, o_irq}, 64'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    rd("rst_ctrl", 4'd7, 32'd0);
    rd("rst_alarm_lo", 4'd5, 32'd0);

    // Tear-free 64-bit read and FREQ
    i_clk_count = 64'h0000_0001_FFFF_FFFF;
    rd("clk_lo", 4'd0, 32'hFFFF_FFFF);
    i_clk_count = 64'h0000_0002_0000_0005;
    rd("clk_hi", 4'd1, 32'h0000_0001);
    rd("freq", 4'd2, 32'd50_000_000);

    // One-shot alarm
    wr("w_alo", 4'd5, 32'd100);
    wr("w_ahi", 4'd6, 32'd0);
    wr("w_ctrl_en", 4'd7, 32'h1);
    step_ms(64'd99);
    chk("irq_before", {63'd0, o_irq}, 64'd0);
    step_ms(64'd100);
    chk("irq_fire", {63'd0, o_irq}, 64'd1);
    rd("ctrl_oneshot", 4'd7, 32'h4);
    rd("ms_lo", 4'd3, 32'd100);
    rd("ms_hi", 4'd4, 32'd0);
    wr("w1c", 4'd7, 32'h4);
    chk("irq_cleared", {63'd0, o_irq}, 64'd0);

    // Periodic with 64-bit wrap
    wr("w_alo2", 4'd5, 32'hFFFF_FFFE);
    wr("w_ahi2", 4'd6, 32'hFFFF_FFFF);
    wr("w_period", 4'd8, 32'd4);
    wr("w_ctrl_per", 4'd7, 32'h3);
    step_ms(64'hFFFF_FFFF_FFFF_FFFE);
    chk("irq_wrapfire", {63'd0, o_irq}, 64'd1);
    @(negedge i_clk);
    i_ms_count = 64'd0;
    rd("alarm_lo_wrap", 4'd5, 32'd2);
    rd("alarm_hi_wrap", 4'd6, 32'd0);
    rd("ctrl_per", 4'd7, 32'h7);
    wr("w1c_per", 4'd7, 32'h7);
    chk("irq_per_clr", {63'd0, o_irq}, 64'd0);
    step_ms(64'd2);
    chk("irq_second", {63'd0, o_irq}, 64'd1);

    // W1C on the same edge as a fire (alarm now 6)
    i_ms_count = 64'd6;
    wr("w1c_fire", 4'd7, 32'h7);
    chk("irq_w1c_fire", {63'd0, o_irq}, 64'd1);
    rd("ctrl_w1c_fire", 4'd7, 32'h7);
    rd("alarm_reload", 4'd5, 32'd10);
    // ALARM write while armed disarms
    wr("w_alo_armed", 4'd5, 32'd1000);
    rd("ctrl_disarm", 4'd7, 32'h6);

    // Unmapped address
    rd("unmapped_rd", 4'd12, 32'd0);
    wr("unmapped_wr", 4'd12, 32'hFFFF_FFFF);
    rd("period_keep", 4'd8, 32'd4);
    rd("alarm_keep", 4'd5, 32'd1000);
    rd("ctrl_keep", 4'd7, 32'h6);

    // Async reset between request and ack, with pending high
    @(negedge i_clk);
    i_req = 1'b1; i_we = 1'b0; i_addr = 4'd2;
    #2;
    i_rst = 1'b1;
    #1;
    chk("rst_async_irq", {63'd0, o_irq}, 64'd0);
    @(posedge i_clk);
    #1;
    i_req = 1'b0;
    chk("rst_async_ack", {63'd0, o_ack}, 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    rd("post_alo", 4'd5, 32'd0);
    rd("post_ahi", 4'd6, 32'd0);
    rd("post_ctrl", 4'd7, 32'd0);
    rd("post_period", 4'd8, 32'd0);
    rd("post_clkhi", 4'd1, 32'd0);
    rd("post_mshi", 4'd4, 32'd0);
    @(posedge i_clk);
    #1;
    chk("ack_idle", {63'd0, o_ack}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
